// File: rtl/simple_fifo_adapter.sv
// Width-up FIFO: packs DATA_IN_WIDTH writes little-endian into DATA_OUT_WIDTH words, with frame-last support.
// Define SIMPLE_FIFO_ADAPTER_FWFT_EN for a show-ahead read port; otherwise read data is registered.
module simple_fifo_adapter #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int ADDR_WIDTH     = 4,
    parameter int FULL_SLACK     = 1,
    parameter int USE_LAST       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_ena,
    input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
    input  logic                      wr_last,
    output logic                      wr_full,
    input  logic                      rd_ena,
    output logic [DATA_OUT_WIDTH-1:0] rd_dat,
    output logic                      rd_last,
    output logic                      rd_empty,
    output logic [ADDR_WIDTH:0]       rd_dat_cnt
);
    localparam int RATIO  = DATA_OUT_WIDTH / DATA_IN_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0]   LAST_LANE  = LANE_W'(RATIO - 1);
    localparam logic [ADDR_WIDTH:0] CNT_MAX    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);

    logic [DATA_OUT_WIDTH-1:0] mem_data [DEPTH];
    logic                      mem_last [DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]       count, count_next;
    logic [LANE_W-1:0]         lane;
    logic [DATA_OUT_WIDTH-1:0] pack_reg, pack_merged;
    logic                      last_in, commit_req, commit_ok, wr_accept, rd_accept;

    assign last_in    = (USE_LAST != 0) && wr_last;
    assign rd_accept  = rd_ena && (count != '0);
    assign commit_req = wr_ena && ((lane == LAST_LANE) || last_in);
    // A commit into a full store only proceeds if a read frees a slot on the same edge.
    assign commit_ok  = commit_req && ((count != CNT_MAX) || rd_accept);
    assign wr_accept  = wr_ena && (!commit_req || commit_ok);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pack_merged = pack_reg;
        for (int k = 0; k < RATIO; k++) begin
            if (lane == LANE_W'(k)) begin
                pack_merged[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({commit_ok, rd_accept})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lane     <= '0;
            pack_reg <= '0;
            wr_full  <= (FULL_LEVEL == '0);
        end else begin
            count   <= count_next;
            wr_full <= (count_next >= FULL_LEVEL);
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
            if (commit_ok) wr_ptr <= wr_ptr + 1'b1;
            if (wr_accept) begin
                if (commit_req) begin
                    lane     <= '0;
                    pack_reg <= '0;
                end else begin
                    lane     <= lane + 1'b1;
                    pack_reg <= pack_merged;
                end
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            mem_data[wr_ptr] <= pack_merged;
            mem_last[wr_ptr] <= last_in;
        end
    end

`ifdef SIMPLE_FIFO_ADAPTER_FWFT_EN
    assign rd_dat  = rd_empty ? '0 : mem_data[rd_ptr];
    assign rd_last = !rd_empty && mem_last[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat  <= '0;
            rd_last <= 1'b0;
        end else if (rd_accept) begin
            rd_dat  <= mem_data[rd_ptr];
            rd_last <= mem_last[rd_ptr];
        end
    end
`endif

    assign rd_empty   = (count == '0);
    assign rd_dat_cnt = count;
endmodule

// File: tb/tb_simple_fifo_adapter.sv
// Self-checking bench for simple_fifo_adapter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_simple_fifo_adapter;
    localparam int DIW = 16;
    localparam int DOW = 128;
    localparam int AW  = 4;
    localparam int FS  = 1;
    localparam int R   = DOW / DIW;
    localparam int D   = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_ena = 1'b0, wr_last = 1'b0, rd_ena = 1'b0;
    logic [DIW-1:0] wr_dat = '0;
    logic           wr_full, rd_last, rd_empty;
    logic [DOW-1:0] rd_dat;
    logic [AW:0]    rd_dat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: partial input words, FIFO of {last, word}, registered read output.
    logic [DIW-1:0] m_part[$];
    logic [DOW:0]   m_q[$];
    logic [DOW-1:0] m_rd_dat = '0;
    logic           m_rd_last = 1'b0;

    simple_fifo_adapter #(
        .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .ADDR_WIDTH(AW),
        .FULL_SLACK(FS), .USE_LAST(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_last(wr_last), .wr_full(wr_full),
        .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_last(rd_last),
        .rd_empty(rd_empty), .rd_dat_cnt(rd_dat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DOW-1:0] obs, input logic [DOW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit we, input logic [DIW-1:0] wd, input bit wl, input bit re);
        bit rd_acc = re && (m_q.size() > 0);
        bit commit = we && ((m_part.size() == R - 1) || wl);
        bit drop   = commit && (m_q.size() == D) && !rd_acc;
        if (rd_acc) {m_rd_last, m_rd_dat} = m_q.pop_front();
        if (we && !drop) begin
            m_part.push_back(wd);
            if (commit) begin
                logic [DOW-1:0] w = '0;
                foreach (m_part[k]) w |= DOW'(m_part[k]) << (k * DIW);
                m_q.push_back({wl, w});
                m_part.delete();
            end
        end
    endtask

    task automatic compare_all(input string pfx);
        logic [DOW-1:0] exp_dat;
        logic           exp_last;
`ifdef SIMPLE_FIFO_ADAPTER_FWFT_EN
        exp_dat  = (m_q.size() > 0) ? m_q[0][DOW-1:0] : '0;
        exp_last = (m_q.size() > 0) ? m_q[0][DOW] : 1'b0;
`else
        exp_dat  = m_rd_dat;
        exp_last = m_rd_last;
`endif
        check({pfx, "_cnt"},   DOW'(rd_dat_cnt), DOW'(m_q.size()));
        check({pfx, "_empty"}, DOW'(rd_empty),   DOW'(m_q.size() == 0));
        check({pfx, "_full"},  DOW'(wr_full),    DOW'(m_q.size() >= D - FS));
        check({pfx, "_dat"},   rd_dat,           exp_dat);
        check({pfx, "_last"},  DOW'(rd_last),    DOW'(exp_last));
    endtask

    task automatic cycle(input string pfx, input bit we, input logic [DIW-1:0] wd,
                         input bit wl, input bit re);
        wr_ena = we; wr_dat = wd; wr_last = wl; rd_ena = re;
        @(posedge clk);
        model_edge(we, wd, wl, re);
        @(negedge clk);
        wr_ena = 1'b0; rd_ena = 1'b0; wr_last = 1'b0;
        compare_all(pfx);
    endtask

    // Pops one word and returns what the read port delivered for it.
    task automatic read_word(input string pfx, output logic [DOW-1:0] d, output logic l);
`ifdef SIMPLE_FIFO_ADAPTER_FWFT_EN
        d = rd_dat; l = rd_last;
        cycle(pfx, 1'b0, '0, 1'b0, 1'b1);
`else
        cycle(pfx, 1'b0, '0, 1'b0, 1'b1);
        d = rd_dat; l = rd_last;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_ena = 1'b1; wr_dat = DIW'($urandom); wr_last = 1'b1; rd_ena = 1'b1;
        @(posedge clk);
        m_part.delete(); m_q.delete(); m_rd_dat = '0; m_rd_last = 1'b0;
        @(negedge clk);
        rst = 1'b0; wr_ena = 1'b0; wr_last = 1'b0; rd_ena = 1'b0;
        compare_all("rst");
    endtask

    function automatic logic [DOW-1:0] lanes_from(input int base);
        logic [DOW-1:0] w = '0;
        for (int j = 0; j < R; j++) w[j*DIW +: DIW] = DIW'(base + j);
        return w;
    endfunction

    initial begin
        logic [DOW-1:0] d;
        logic           l;

        // Reset state and a frame of 32 words ending with last.
        do_reset();
        for (int i = 0; i < 32; i++) cycle("f32_wr", 1'b1, DIW'(i), i == 31, 1'b0);
        check("f32_cnt4", DOW'(rd_dat_cnt), DOW'(4));
        for (int i = 0; i < 4; i++) begin
            read_word("f32_rd", d, l);
            if (i == 0) check("f32_word0", d, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
            check("f32_lastflag", DOW'(l), DOW'(i == 3));
        end
        check("f32_empty", DOW'(rd_empty), DOW'(1));

        // Fill completely without last; early-full and little-endian packing.
        do_reset();
        for (int i = 0; i < 128; i++) cycle("fill_wr", 1'b1, DIW'(i), 1'b0, 1'b0);
        check("fill_cnt16", DOW'(rd_dat_cnt), DOW'(16));
        check("fill_full", DOW'(wr_full), DOW'(1));
        for (int k = 0; k < 16; k++) begin
            read_word("fill_rd", d, l);
            check("fill_word", d, lanes_from(8 * k));
        end
        check("fill_empty", DOW'(rd_empty), DOW'(1));

        // Short frame: early commit zero-fills upper lanes.
        do_reset();
        cycle("short_wr", 1'b1, 16'h000A, 1'b0, 1'b0);
        cycle("short_wr", 1'b1, 16'h000B, 1'b0, 1'b0);
        cycle("short_wr", 1'b1, 16'h000C, 1'b1, 1'b0);
        read_word("short_rd", d, l);
        check("short_word", d, 128'h0000_0000_0000_0000_0000_000C_000B_000A);
        check("short_lastflag", DOW'(l), DOW'(1));

        // Overflow: extra commit dropped, stored words intact.
        do_reset();
        for (int i = 0; i < 128; i++) cycle("ovf_wr", 1'b1, DIW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("ovf_extra", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("ovf_cnt16", DOW'(rd_dat_cnt), DOW'(16));
        for (int k = 0; k < 16; k++) begin
            read_word("ovf_rd", d, l);
            check("ovf_word", d, lanes_from(8 * k));
        end

        // Concurrent commits and reads.
        do_reset();
        for (int i = 0; i < 16; i++) cycle("cc_pre", 1'b1, DIW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) cycle("cc_wr", 1'b1, 16'h0009, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            cycle("cc_rw", 1'b1, 16'h0009, 1'b0, 1'b1);
            check("cc_cnt_max", DOW'(rd_dat_cnt <= D), DOW'(1));
        end
        while (!rd_empty) cycle("cc_drain", 1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation discards stored and partial data.
        do_reset();
        for (int i = 0; i < 8; i++) cycle("mid_wr", 1'b1, DIW'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("mid_part", 1'b1, DIW'(200 + i), 1'b0, 1'b0);
        do_reset();
        check("mid_empty", DOW'(rd_empty), DOW'(1));
        check("mid_cnt0", DOW'(rd_dat_cnt), DOW'(0));
        check("mid_dat0", rd_dat, '0);
        for (int i = 0; i < 8; i++) cycle("mid_fresh", 1'b1, DIW'(16 + i), 1'b0, 1'b0);
        read_word("mid_rd", d, l);
        check("mid_fresh_word", d, lanes_from(16));

        // Random traffic with phases biased toward filling and draining.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int wp = ((i / 150) % 2 == 0) ? 85 : 35;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle("rnd", $urandom_range(0, 99) < wp, DIW'($urandom),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 99) < (120 - wp));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/simple_fifo_adapter.md
SIMPLE_FIFO_ADAPTER -- requirements
Module: simple_fifo_adapter

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 16: write word width in bits.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 128: read word width in bits; an integer multiple R = DATA_OUT_WIDTH/DATA_IN_WIDTH ≥ 1.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: storage depth D = 2^ADDR_WIDTH output words.
REQ-004 SHALL have parameter FULL_SLACK, default 1: early-full margin in output words, 0 ≤ FULL_SLACK < D.
REQ-005 SHALL have parameter USE_LAST, default 1: 1 enables frame-last handling; 0 ignores wr_last and ties rd_last to 0.
REQ-006 SHALL have ports: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: wr_ena in 1, write strobe; wr_dat in DATA_IN_WIDTH, write data; wr_last in 1, last input word of frame; wr_full out 1, early-full flag.
REQ-008 SHALL have ports: rd_ena in 1, read strobe; rd_dat out DATA_OUT_WIDTH, read data; rd_last out 1, frame-last flag of rd_dat; rd_empty out 1; rd_dat_cnt out ADDR_WIDTH+1, stored output-word count.

Function
REQ-009 Input words SHALL be packed little-endian: the k-th accepted word of a group (k=0..R-1) goes to bits [k*DATA_IN_WIDTH +: DATA_IN_WIDTH].
REQ-010 A packed word SHALL commit to storage on the clock edge accepting its R-th input word, or, with USE_LAST=1, the edge accepting an input word with wr_last=1.
REQ-011 Early-committed word unused lanes SHALL be zero; the stored word carries last=1; the packing counter restarts at lane 0.
REQ-012 rd_dat_cnt SHALL count committed, unread words (0..D), excluding the partial packing register; rd_empty = (rd_dat_cnt==0).
REQ-013 wr_full SHALL be registered and equal (rd_dat_cnt ≥ D-FULL_SLACK); advisory only.
REQ-014 A write that would commit while rd_dat_cnt==D and no read is accepted the same edge SHALL be dropped entirely (packing register unchanged); non-committing writes are always accepted.
REQ-015 rd_ena with rd_empty=1 SHALL be ignored; read and commit on the same edge SHALL both occur, count unchanged.
REQ-016 Without the configuration macro, rd_dat/rd_last SHALL be registered: an accepted read updates them on that edge with the oldest word; otherwise they hold.
REQ-017 Pointers SHALL wrap modulo D; order strictly FIFO.

Reset
REQ-018 On rst=1 at a clk edge: pointers, count, packing lane and register cleared; rd_dat=0, rd_last=0, rd_empty=1, rd_dat_cnt=0, wr_full=0 (1 only if D-FULL_SLACK==0).
REQ-019 Reset mid-operation SHALL discard stored and partial data; wr_ena/rd_ena during reset ignored.

Configuration
REQ-020 Macro SIMPLE_FIFO_ADAPTER_FWFT_EN: defined -> rd_dat/rd_last combinationally present the oldest stored word whenever rd_empty=0 (show-ahead), rd_ena pops it; undefined -> registered read per REQ-016.

Verification
REQ-021 Write 0..31 (16-bit), wr_last on 31, then 4 reads -> rd_dat_cnt 4 before reads; first word 0x0007_0006_0005_0004_0003_0002_0001_0000; rd_last=1 only on fourth; empty after.
REQ-022 Write 0..127, no last -> rd_dat_cnt 16, wr_full=1 from cnt 15; 16 reads return word k = {8k+7,...,8k}; rd_empty=1 at end.
REQ-023 Write 0xA,0xB,0xC with wr_last on 0xC -> one word 0x...0000_000C_000B_000A, upper lanes zero, rd_last=1.
REQ-024 Full FIFO (16 words) plus 8 more writes without read -> cnt stays 16, extra word dropped; reads return original 16 words.
REQ-025 Two words stored, continuous wr_ena with wr_dat=9 for 32 cycles then rd_ena overlapped for 32 cycles -> commits and reads coexist, cnt never exceeds 16, read words all 0x0009 lanes after the two originals.
REQ-026 Assert rst after 3 writes and 1 commit -> next edge rd_empty=1, cnt 0, rd_dat 0; next 8 writes form a fresh word from lane 0.
